glyph_loader: RTL



---
 rtl/glyph_pkg.sv | 23 ++
 rtl/glyph_ram.sv | 53 +++++
 rtl/glyph_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/glyph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_pkg
//  Description : Shared constants and types for the glyph loader and its RAM.
//                Glyph geometry (rows x columns), the header sync bit position
//                and the loader FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package glyph_pkg;

    localparam int GLYPH_ROWS   = 12;  // rows per glyph
    localparam int GLYPH_COLS   = 12;  // bits per row, bit 11 = leftmost pixel
    localparam int HDR_SYNC_BIT = 7;   // set only in header bytes

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HI     = 2'd1,
        LO     = 2'd2,
        COMMIT = 2'd3
    } loader_state_t;

endpackage : glyph_pkg
`default_nettype wire

// File: rtl/glyph_ram.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_ram
//  Description : Simple dual-port glyph RAM. One synchronous write port and
//                one registered, read-first read port. When rd_en_i is low
//                the read register loads zero, which gives out-of-range reads
//                a defined value.
//  Ports       : clk_in, rst_n_in        - clock, async active-low reset
//                we_i/wr_addr_i/wr_data_i - write port
//                rd_en_i/rd_addr_i        - read request
//                rd_data_o                - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_ram #(
    parameter int DEPTH = 384,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             we_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage carries no reset; contents are qualified by the loaded mask.
    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking read of the array on the write edge returns the old word.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : glyph_ram
`default_nettype wire

// File: rtl/glyph_loader.sv
`default_nettype none
// ============================================================================
//  Module      : glyph_loader
//  Description : Writer side of the glyph store. Parses a byte stream of
//                glyph frames (header + GLYPH_ROWS hi/lo byte pairs) into a
//                glyph RAM, tracks which slots hold complete bitmaps and
//                offers a registered row-read port to the renderer.
//  Ports       : clk_in, rst_n_in             - clock, async active-low reset
//                byte_in/byte_valid_in/byte_ready_out - stream handshake
//                rd_letter_in/rd_row_in/rd_bits_out  - row read port
//                busy_out, done_out, error_out - load status
//                loaded_mask_out               - per-slot complete flags
//  Revision    : 1.0 - initial release
// ============================================================================
module glyph_loader
    import glyph_pkg::*;
#(
    parameter int NUM_GLYPHS = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    output logic                  byte_ready_out,
    input  logic [4:0]            rd_letter_in,
    input  logic [3:0]            rd_row_in,
    output logic [GLYPH_COLS-1:0] rd_bits_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out,
    output logic [NUM_GLYPHS-1:0] loaded_mask_out
);

    localparam int DEPTH = NUM_GLYPHS * GLYPH_ROWS;
    localparam int AW    = $clog2(DEPTH);

    loader_state_t         state_q, state_d;
    logic [4:0]            letter_q, letter_d;
    logic [3:0]            row_cnt_q, row_cnt_d;
    logic [3:0]            nib_q, nib_d;
    logic [NUM_GLYPHS-1:0] mask_q, mask_d;
    logic                  error_q, error_d;

    logic                  xfer_w;
    logic                  hdr_ok_w;
    logic                  we_w;
    logic                  rd_en_w;
    logic [AW-1:0]         wr_addr_w;
    logic [AW-1:0]         rd_addr_w;

    assign xfer_w   = byte_valid_in && byte_ready_out;
    assign hdr_ok_w = (byte_in[6:5] == 2'b00) && (int'(byte_in[4:0]) < NUM_GLYPHS);

    // Slot base is formed at full address width so letter*rows never wraps.
    assign wr_addr_w = AW'(letter_q) * AW'(GLYPH_ROWS) + AW'(row_cnt_q);
    assign rd_addr_w = AW'(rd_letter_in) * AW'(GLYPH_ROWS) + AW'(rd_row_in);
    assign rd_en_w   = (int'(rd_row_in) < GLYPH_ROWS) && (int'(rd_letter_in) < NUM_GLYPHS);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            letter_q  <= '0;
            row_cnt_q <= '0;
            nib_q     <= '0;
            mask_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            letter_q  <= letter_d;
            row_cnt_q <= row_cnt_d;
            nib_q     <= nib_d;
            mask_q    <= mask_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        letter_d       = letter_q;
        row_cnt_d      = row_cnt_q;
        nib_d          = nib_q;
        mask_d         = mask_q;
        error_d        = 1'b0;
        we_w           = 1'b0;
        byte_ready_out = 1'b1;

        case (state_q)
            IDLE: begin
                // Bytes without the sync bit are dropped so the stream can resync.
                if (xfer_w && byte_in[HDR_SYNC_BIT]) begin
                    if (hdr_ok_w) begin
                        letter_d               = byte_in[4:0];
                        row_cnt_d              = '0;
                        mask_d[byte_in[4:0]]   = 1'b0;
                        state_d                = HI;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            HI: begin
                // A non-zero upper nibble also covers a header arriving mid-frame.
                if (xfer_w) begin
                    if (byte_in[7:4] != 4'h0) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        nib_d   = byte_in[3:0];
                        state_d = LO;
                    end
                end
            end
            LO: begin
                if (xfer_w) begin
                    we_w = 1'b1;
                    if (row_cnt_q == 4'(GLYPH_ROWS - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        row_cnt_d = row_cnt_q + 4'd1;
                        state_d   = HI;
                    end
                end
            end
            COMMIT: begin
                byte_ready_out   = 1'b0;
                mask_d[letter_q] = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    glyph_ram #(
        .DEPTH (DEPTH),
        .WIDTH (GLYPH_COLS),
        .AW    (AW)
    ) u_ram (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .we_i      (we_w),
        .wr_addr_i (wr_addr_w),
        .wr_data_i ({nib_q, byte_in}),
        .rd_en_i   (rd_en_w),
        .rd_addr_i (rd_addr_w),
        .rd_data_o (rd_bits_out)
    );

    assign busy_out        = (state_q != IDLE);
    assign done_out        = (state_q == COMMIT);
    assign error_out       = error_q;
    assign loaded_mask_out = mask_q;

endmodule : glyph_loader
`default_nettype wire
